// File: rtl/locked_reg_pkg.sv
`default_nettype none
// locked_reg_pkg: lock-state encoding, default unlock keys and one-hot helper.
// Rev 1.0
package locked_reg_pkg;

  typedef enum logic [1:0] {
    UNLOCKED  = 2'd0,
    LOCKED    = 2'd1,
    KEY1_WAIT = 2'd2,
    LOCKOUT   = 2'd3
  } state_t;

  localparam logic [7:0] DEF_KEY0 = 8'hA5;
  localparam logic [7:0] DEF_KEY1 = 8'h5A;

  localparam int ONEHOT_IW  = 6;
  localparam int ONEHOT_MAX = 1 << ONEHOT_IW;

  // Out-of-range indices yield all zeros, so callers can truncate safely.
  function automatic logic [ONEHOT_MAX-1:0] reg_onehot(input int unsigned idx);
    logic [ONEHOT_MAX-1:0] v;
    v = '0;
    if (idx < 32'(ONEHOT_MAX)) v[idx[ONEHOT_IW-1:0]] = 1'b1;
    return v;
  endfunction

endpackage
`default_nettype wire

// File: rtl/locked_reg_lockout_timer.sv
`default_nettype none
// locked_reg_lockout_timer: loadable down-counter that pulses done when it reaches zero.
// Rev 1.0
module locked_reg_lockout_timer #(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             done
);

  logic [CNT_W-1:0] r_count;
  logic             r_busy;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_count <= '0;
      r_busy  <= 1'b0;
    end else if (load) begin
      r_count <= load_val;
      r_busy  <= 1'b1;
    end else if (r_busy) begin
      if (r_count == '0) begin
        r_busy <= 1'b0;
      end else begin
        r_count <= r_count - 1'b1;
      end
    end
  end

  assign done = r_busy & (r_count == '0);

endmodule
`default_nettype wire

// File: rtl/locked_reg_write_ctrl.sv
`default_nettype none
// locked_reg_write_ctrl: valid/ready write front-end for a locked register bank with key unlock.
// Rev 1.0
module locked_reg_write_ctrl
  import locked_reg_pkg::*;
#(
  parameter int                DATA_W       = 8,
  parameter int                NUM_REGS     = 4,
  parameter logic [DATA_W-1:0] KEY0         = DATA_W'(DEF_KEY0),
  parameter logic [DATA_W-1:0] KEY1         = DATA_W'(DEF_KEY1),
  parameter int                MAX_FAIL     = 3,
  parameter int                LOCKOUT_CYC  = 16,
  parameter bit                RESET_LOCKED = 1'b1,
  localparam int               ADDR_W       = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [DATA_W-1:0]   req_data,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic                rsp_err,
  input  logic                lock_set,
  input  logic                key_valid,
  input  logic [DATA_W-1:0]   key_data,
  output logic [NUM_REGS-1:0] reg_we,
  output logic [DATA_W-1:0]   reg_wdata,
  output logic                locked,
  output logic                lockout
);

  localparam int     FAIL_W      = $clog2(MAX_FAIL + 1);
  localparam int     TMR_W       = (LOCKOUT_CYC > 1) ? $clog2(LOCKOUT_CYC) : 1;
  localparam state_t RESET_STATE = RESET_LOCKED ? LOCKED : UNLOCKED;

  state_t              r_state;
  state_t              w_state_d;
  logic [FAIL_W-1:0]   r_fail_cnt;
  logic [FAIL_W-1:0]   w_fail_d;
  logic [FAIL_W-1:0]   w_fail_inc;
  logic                w_fail_bump;
  logic                w_tmr_load;
  logic                w_tmr_done;
  logic                r_locked;
  logic                r_lockout;

  logic                r_rsp_valid;
  logic                r_rsp_err;
  logic [NUM_REGS-1:0] r_reg_we;
  logic [DATA_W-1:0]   r_reg_wdata;
  logic                w_accept;
  logic                w_addr_ok;
  logic                w_permit;
  logic [NUM_REGS-1:0] w_onehot;

  assign w_fail_inc = r_fail_cnt + FAIL_W'(1);

  // Lock requests take priority over key words in every state.
  always_comb begin
    w_state_d   = r_state;
    w_fail_d    = r_fail_cnt;
    w_fail_bump = 1'b0;
    w_tmr_load  = 1'b0;
    case (r_state)
      UNLOCKED: begin
        if (lock_set) w_state_d = LOCKED;
      end
      LOCKED: begin
        if (!lock_set && key_valid) begin
          if (key_data == KEY0) w_state_d = KEY1_WAIT;
          else                  w_fail_bump = 1'b1;
        end
      end
      KEY1_WAIT: begin
        if (lock_set) begin
          w_state_d = LOCKED;
        end else if (key_valid) begin
          if (key_data == KEY1) begin
            w_state_d = UNLOCKED;
            w_fail_d  = '0;
          end else begin
            w_state_d   = LOCKED;
            w_fail_bump = 1'b1;
          end
        end
      end
      LOCKOUT: begin
        if (w_tmr_done) begin
          w_state_d = LOCKED;
          w_fail_d  = '0;
        end
      end
      default: w_state_d = LOCKED;
    endcase

    if (w_fail_bump) begin
      if (w_fail_inc == FAIL_W'(MAX_FAIL)) begin
        w_state_d  = LOCKOUT;
        w_tmr_load = 1'b1;
        w_fail_d   = w_fail_inc;
      end else if (r_fail_cnt != FAIL_W'(MAX_FAIL)) begin
        w_fail_d = w_fail_inc;
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state    <= RESET_STATE;
      r_fail_cnt <= '0;
      r_locked   <= RESET_LOCKED;
      r_lockout  <= 1'b0;
    end else begin
      r_state    <= w_state_d;
      r_fail_cnt <= w_fail_d;
      r_locked   <= (w_state_d != UNLOCKED);
      r_lockout  <= (w_state_d == LOCKOUT);
    end
  end

  locked_reg_lockout_timer #(
    .CNT_W (TMR_W)
  ) u_timer (
    .clk      (clk),
    .resetn   (resetn),
    .load     (w_tmr_load),
    .load_val (TMR_W'(LOCKOUT_CYC - 1)),
    .done     (w_tmr_done)
  );

  // Permission is judged on the pre-update state; an index outside the bank is rejected.
  assign w_accept  = req_valid & ~r_rsp_valid;
  assign w_addr_ok = (32'(req_addr) < 32'(NUM_REGS));
  assign w_permit  = w_accept & (r_state == UNLOCKED) & ~lock_set & w_addr_ok;
  assign w_onehot  = NUM_REGS'(reg_onehot(32'(req_addr)));

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_rsp_valid <= 1'b0;
      r_rsp_err   <= 1'b0;
      r_reg_we    <= '0;
      r_reg_wdata <= '0;
    end else begin
      r_reg_we <= '0;
      if (w_accept) begin
        r_rsp_valid <= 1'b1;
        r_rsp_err   <= ~w_permit;
        if (w_permit) begin
          r_reg_we    <= w_onehot;
          r_reg_wdata <= req_data;
        end
      end else if (r_rsp_valid && rsp_ready) begin
        r_rsp_valid <= 1'b0;
        r_rsp_err   <= 1'b0;
      end
    end
  end

  assign req_ready = ~r_rsp_valid;
  assign rsp_valid = r_rsp_valid;
  assign rsp_err   = r_rsp_err;
  assign reg_we    = r_reg_we;
  assign reg_wdata = r_reg_wdata;
  assign locked    = r_locked;
  assign lockout   = r_lockout;

endmodule
`default_nettype wire

// File: tb/tb_locked_reg_write_ctrl.sv
`default_nettype none
// tb_locked_reg_write_ctrl: directed plus randomized stimulus against a behavioural lock model.
// Rev 1.0
module tb_locked_reg_write_ctrl;

  localparam int         NUM_REGS     = 4;
  localparam int         MAX_FAIL     = 3;
  localparam int         LOCKOUT_CYC  = 16;
  localparam bit         RESET_LOCKED = 1'b0;
  localparam logic [7:0] K0           = 8'hA5;
  localparam logic [7:0] K1           = 8'h5A;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic       req_valid = 1'b0;
  logic       req_ready;
  logic [1:0] req_addr = '0;
  logic [7:0] req_data = '0;
  logic       rsp_valid;
  logic       rsp_ready = 1'b0;
  logic       rsp_err;
  logic       lock_set = 1'b0;
  logic       key_valid = 1'b0;
  logic [7:0] key_data = '0;
  logic [3:0] reg_we;
  logic [7:0] reg_wdata;
  logic       locked;
  logic       lockout;

  always #5 clk = ~clk;

  locked_reg_write_ctrl #(
    .DATA_W       (8),
    .NUM_REGS     (NUM_REGS),
    .KEY0         (K0),
    .KEY1         (K1),
    .MAX_FAIL     (MAX_FAIL),
    .LOCKOUT_CYC  (LOCKOUT_CYC),
    .RESET_LOCKED (RESET_LOCKED)
  ) dut (
    .clk       (clk),
    .resetn    (resetn),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_addr  (req_addr),
    .req_data  (req_data),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_err   (rsp_err),
    .lock_set  (lock_set),
    .key_valid (key_valid),
    .key_data  (key_data),
    .reg_we    (reg_we),
    .reg_wdata (reg_wdata),
    .locked    (locked),
    .lockout   (lockout)
  );

  typedef struct {
    bit         err;
    logic [3:0] we;
    logic [7:0] wdata;
  } rsp_t;

  rsp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  // Reference model: plain flags and counters describing the lock rules.
  bit         m_unlocked;
  bit         m_wait2;
  bit         m_pend;
  int         m_fails;
  int         m_lo;
  logic [7:0] m_wdata;

  bit         exp_locked = RESET_LOCKED;
  bit         exp_lockout = 1'b0;
  bit         exp_rsp_valid = 1'b0;
  logic [3:0] exp_we = '0;
  logic [7:0] exp_wdata = '0;
  bit         want_rstn = 1'b0;
  bit         mon_prev_valid = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic publish();
    exp_locked    = !m_unlocked;
    exp_lockout   = (m_lo > 0);
    exp_rsp_valid = m_pend;
    exp_wdata     = m_wdata;
  endtask

  task automatic model_reset();
    m_unlocked = !RESET_LOCKED;
    m_wait2    = 1'b0;
    m_pend     = 1'b0;
    m_fails    = 0;
    m_lo       = 0;
    m_wdata    = '0;
    exp_we     = '0;
    exp_q.delete();
    publish();
  endtask

  task automatic model_step();
    bit accept;
    bit permit;
    accept = req_valid && !m_pend;
    permit = accept && m_unlocked && !lock_set;
    exp_we = permit ? (4'b0001 << req_addr) : 4'b0000;
    if (permit) m_wdata = req_data;
    if (accept) begin
      m_pend = 1'b1;
      exp_q.push_back('{err: !permit, we: exp_we, wdata: m_wdata});
    end else if (m_pend && rsp_ready) begin
      m_pend = 1'b0;
    end

    if (m_lo > 0) begin
      m_lo--;
      if (m_lo == 0) m_fails = 0;
    end else if (m_unlocked) begin
      if (lock_set) m_unlocked = 1'b0;
    end else if (lock_set) begin
      m_wait2 = 1'b0;
    end else if (key_valid) begin
      if (m_wait2 && key_data == K1) begin
        m_unlocked = 1'b1;
        m_wait2    = 1'b0;
        m_fails    = 0;
      end else if (!m_wait2 && key_data == K0) begin
        m_wait2 = 1'b1;
      end else begin
        m_wait2 = 1'b0;
        m_fails++;
        if (m_fails == MAX_FAIL) m_lo = LOCKOUT_CYC;
      end
    end
    publish();
  endtask

  task automatic step(input bit rv, input logic [1:0] ra, input logic [7:0] rd, input bit rr,
                      input bit ls, input bit kv, input logic [7:0] kd);
    @(negedge clk);
    resetn    = want_rstn;
    req_valid = rv;
    req_addr  = ra;
    req_data  = rd;
    rsp_ready = rr;
    lock_set  = ls;
    key_valid = kv;
    key_data  = kd;
    if (!resetn) model_reset();
    else         model_step();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 2'd0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00);
  endtask

  task automatic wr(input logic [1:0] a, input logic [7:0] d);
    step(1'b1, a, d, 1'b1, 1'b0, 1'b0, 8'h00);
    idle(2);
  endtask

  task automatic key(input logic [7:0] k);
    step(1'b0, 2'd0, 8'h00, 1'b1, 1'b0, 1'b1, k);
  endtask

  task automatic lock_pulse();
    step(1'b0, 2'd0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h00);
  endtask

  // Monitor: per-cycle output checks plus scoreboard pop on each new response.
  initial begin
    rsp_t e;
    forever begin
      @(posedge clk);
      #1;
      chk("locked", 32'(locked), 32'(exp_locked));
      chk("lockout", 32'(lockout), 32'(exp_lockout));
      chk("rsp_valid", 32'(rsp_valid), 32'(exp_rsp_valid));
      chk("req_ready", 32'(req_ready), 32'(!exp_rsp_valid));
      chk("reg_we", 32'(reg_we), 32'(exp_we));
      chk("reg_wdata", 32'(reg_wdata), 32'(exp_wdata));
      if (rsp_valid && !mon_prev_valid) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL rsp_unexpected: got a response with an empty scoreboard at %0t", $time);
        end else begin
          e = exp_q.pop_front();
          chk("rsp_err", 32'(rsp_err), 32'(e.err));
          chk("rsp_we", 32'(reg_we), 32'(e.we));
          chk("rsp_wdata", 32'(reg_wdata), 32'(e.wdata));
        end
      end
      mon_prev_valid = rsp_valid;
    end
  end

  initial begin
    logic [7:0]  kd;
    int unsigned r;
    model_reset();
    want_rstn = 1'b0;
    idle(3);
    want_rstn = 1'b1;
    idle(2);

    // 1: unlocked write lands on reg 2
    wr(2'd2, 8'h3C);
    // 2: locked write is rejected
    lock_pulse();
    wr(2'd1, 8'h77);
    // 3: two-word unlock, then write reg 0
    key(K0);
    key(K1);
    idle(1);
    wr(2'd0, 8'h11);
    // 4: three wrong words force lockout; keys and writes ignored meanwhile
    lock_pulse();
    key(8'h00);
    key(K0);
    key(8'h99);
    key(8'hFF);
    key(K0);
    key(K1);
    wr(2'd3, 8'hEE);
    idle(16);
    // 5: lock_set beats a same-cycle write; response held while rsp_ready low
    key(K0);
    key(K1);
    idle(1);
    step(1'b1, 2'd3, 8'hC3, 1'b0, 1'b1, 1'b0, 8'h00);
    for (int i = 0; i < 3; i++) step(1'b1, 2'd1, 8'h42, 1'b0, 1'b0, 1'b0, 8'h00);
    idle(2);
    // 6: reset drops while a permitted write's response is pending
    key(K0);
    key(K1);
    idle(1);
    step(1'b1, 2'd2, 8'h96, 1'b0, 1'b0, 1'b0, 8'h00);
    @(posedge clk);
    #3;
    want_rstn = 1'b0;
    resetn    = 1'b0;
    #1;
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_reg_we", 32'(reg_we), 32'd0);
    model_reset();
    idle(2);
    want_rstn = 1'b1;
    idle(2);

    // Randomized traffic, biased toward the real keys so unlocks happen.
    for (int i = 0; i < 3000; i++) begin
      r  = $urandom_range(0, 9);
      kd = (r < 4) ? K0 : (r < 8) ? K1 : 8'($urandom);
      step(1'($urandom_range(0, 1)), 2'($urandom), 8'($urandom),
           ($urandom_range(0, 9) < 6), ($urandom_range(0, 19) == 0),
           ($urandom_range(0, 3) == 0), kd);
    end
    idle(4);
    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/locked_reg_write_ctrl.md
Name: locked_reg_write_ctrl

Overview:
- Write-side controller for a bank of mux-enabled, async-reset locked registers.
- Accepts write requests over a valid/ready bus and drives one-hot, single-cycle write enables plus write data into the register bank.
- Enforces a sticky lock state and a two-word key unlock sequence with failed-attempt lockout.
- Sits between the configuration bus and the protected register bank.

Parameters:
- DATA_W, 8, width of write data and key words.
- NUM_REGS, 4, number of protected registers; ADDR_W = clog2(NUM_REGS).
- KEY0, 8'hA5, first unlock key word.
- KEY1, 8'h5A, second unlock key word.
- MAX_FAIL, 3, consecutive wrong key words that trigger lockout.
- LOCKOUT_CYC, 16, lockout duration in clk cycles.
- RESET_LOCKED, 1, 1 = leave reset in LOCKED, 0 = leave reset in UNLOCKED.

Ports:
- clk  in  1  clock.
- resetn  in  1  reset, asynchronous, active-low.
- req_valid  in  1  write request valid.
- req_ready  out  1  controller can accept a request.
- req_addr  in  ADDR_W  target register index.
- req_data  in  DATA_W  write data.
- rsp_valid  out  1  response valid; held until rsp_ready.
- rsp_ready  in  1  response consumed.
- rsp_err  out  1  1 = write rejected (locked or lockout).
- lock_set  in  1  pulse: enter LOCKED.
- key_valid  in  1  key word strobe.
- key_data  in  DATA_W  key word.
- reg_we  out  NUM_REGS  one-hot, one-cycle write enable to the register bank.
- reg_wdata  out  DATA_W  write data to the register bank.
- locked  out  1  state != UNLOCKED.
- lockout  out  1  state == LOCKOUT.

Behaviour:
- Reset: state = RESET_LOCKED ? LOCKED : UNLOCKED; fail_cnt = 0; timer = 0; rsp_valid = 0; rsp_err = 0; reg_we = 0; reg_wdata = 0; lockout = 0.
- Handshake:
  - req_ready = ~rsp_valid, so at most one request is outstanding.
  - A request is accepted when req_valid & req_ready.
  - Acceptance in cycle N gives rsp_valid = 1 in N+1. If permitted, reg_we[req_addr] = 1 in N+1 for exactly one cycle, with reg_wdata = req_data.
  - rsp_valid stays high until a cycle with rsp_ready = 1, then clears in the next cycle.
- Permission: a write is permitted only if the state at acceptance is UNLOCKED and lock_set = 0 in that cycle (lock wins).
  - Rejected writes: rsp_err = 1, reg_we stays 0, reg_wdata unchanged.
- States and transitions:
  - UNLOCKED:
    - lock_set -> LOCKED.
    - key_valid is ignored.
  - LOCKED:
    - key_valid & key_data == KEY0 -> KEY1_WAIT.
    - key_valid with any other value -> fail_cnt + 1.
  - KEY1_WAIT:
    - key_valid & key_data == KEY1 -> UNLOCKED, fail_cnt = 0.
    - key_valid with any other value -> LOCKED, fail_cnt + 1.
    - lock_set -> LOCKED, no fail counted.
  - LOCKOUT:
    - Entered when an increment would make fail_cnt == MAX_FAIL; timer loads LOCKOUT_CYC - 1.
    - Timer decrements each cycle; key_valid and lock_set are ignored.
    - At timer == 0 -> LOCKED, fail_cnt = 0.
- Priority in one cycle: lock_set over key_valid; the state update and the write permission decision share that cycle.
- fail_cnt is a saturating counter of width clog2(MAX_FAIL + 1) and never wraps.
- locked and lockout are registered decodes of the state, with no extra latency beyond the state register.
- Reset mid-operation: an asserted resetn drop clears any pending response and any reg_we pulse immediately. A write accepted before reset never produces reg_we after reset.
- Undefined state encodings recover to LOCKED.

Decomposition:
- Package locked_reg_pkg holds:
  - the state enum: UNLOCKED, LOCKED, KEY1_WAIT, LOCKOUT;
  - default KEY0/KEY1 constants;
  - the function computing one-hot from index.
- Sub-module locked_reg_lockout_timer: a down-counter with load/start and a done pulse, async reset via resetn.

Test Plan:
1. RESET_LOCKED = 0; after reset write addr 2, data 8'h3C -> next cycle reg_we = 4'b0100, reg_wdata = 8'h3C, rsp_valid = 1, rsp_err = 0.
2. Pulse lock_set, then write addr 1, data 8'h77 -> rsp_err = 1, reg_we = 0 throughout, locked = 1.
3. Locked; key 8'hA5 then 8'h5A -> locked = 0 the cycle after the second key. Write addr 0, data 8'h11 -> reg_we = 4'b0001.
4. Locked; keys 8'h00, 8'hA5, 8'h99 (fail, fail) -> fail_cnt = 2.
   - Next key 8'hFF -> lockout = 1 for exactly 16 cycles.
   - During lockout, A5/5A do not unlock; afterwards locked = 1, lockout = 0.
5. UNLOCKED; lock_set and an accepted write in the same cycle -> rsp_err = 1, no reg_we. Hold rsp_ready = 0 for 3 cycles -> rsp_valid held, req_ready = 0.
6. Accept a write, then drop resetn in the next cycle before the response -> rsp_valid = 0 and reg_we = 0 immediately. After release the state equals the RESET_LOCKED value.
